// File: rtl/timer_tick_master_if.sv
// rtl/timer_tick_master_if.sv - Avalon-MM link between the tick master and the interval-timer slave
interface timer_tick_master_if;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        timer_irq;

  modport master (
    output av_address, av_chipselect, av_write_n, av_writedata,
    input  av_readdata, timer_irq
  );

  modport slave (
    input  av_address, av_chipselect, av_write_n, av_writedata,
    output av_readdata, timer_irq
  );
endinterface

// File: rtl/timer_tick_master.sv
// rtl/timer_tick_master.sv - hardware master for the interval timer; turns timeouts into a HH:MM:SS clock
module timer_tick_master #(
  parameter logic [31:0] PERIOD     = 32'd49_999_999,
  parameter logic [15:0] CTRL_START = 16'h0007
) (
  input  logic                       clk,
  input  logic                       reset_n,
  timer_tick_master_if.master        bus,
  input  logic                       set_valid,
  input  logic [4:0]                 set_hh,
  input  logic [5:0]                 set_mm,
  input  logic [5:0]                 set_ss,
  output logic                       init_done,
  output logic                       tick,
  output logic [4:0]                 hh,
  output logic [5:0]                 mm,
  output logic [5:0]                 ss,
  output logic                       stall_err
);

  typedef enum logic [2:0] {
    W_PERL, W_PERH, W_CTRL, IDLE, RD_ADDR, RD_CAP, W_STAT, GUARD
  } state_t;

  state_t state;
  logic   restart;

  // Bus outputs are registered: each state loads the bus cycle for the next clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= W_PERL;
      restart           <= 1'b0;
      init_done         <= 1'b0;
      tick              <= 1'b0;
      stall_err         <= 1'b0;
      bus.av_address    <= 3'd0;
      bus.av_chipselect <= 1'b0;
      bus.av_write_n    <= 1'b1;
      bus.av_writedata  <= 16'h0000;
    end else begin
      bus.av_address    <= 3'd0;
      bus.av_chipselect <= 1'b0;
      bus.av_write_n    <= 1'b1;
      bus.av_writedata  <= 16'h0000;
      tick              <= 1'b0;
      case (state)
        W_PERL: begin
          bus.av_address    <= 3'd2;
          bus.av_chipselect <= 1'b1;
          bus.av_write_n    <= 1'b0;
          bus.av_writedata  <= PERIOD[15:0];
          state             <= W_PERH;
        end
        W_PERH: begin
          bus.av_address    <= 3'd3;
          bus.av_chipselect <= 1'b1;
          bus.av_write_n    <= 1'b0;
          bus.av_writedata  <= PERIOD[31:16];
          state             <= W_CTRL;
        end
        W_CTRL: begin
          bus.av_address    <= 3'd1;
          bus.av_chipselect <= 1'b1;
          bus.av_write_n    <= 1'b0;
          bus.av_writedata  <= CTRL_START;
          init_done         <= 1'b1;
          state             <= IDLE;
        end
        IDLE: begin
          if (bus.timer_irq) begin
            bus.av_chipselect <= 1'b1;
            state             <= RD_ADDR;
          end
        end
        RD_ADDR: state <= RD_CAP;
        RD_CAP: begin
          if (bus.av_readdata[0]) begin
            bus.av_chipselect <= 1'b1;
            bus.av_write_n    <= 1'b0;
            tick              <= 1'b1;
            restart           <= ~bus.av_readdata[1];
            if (!bus.av_readdata[1])
              stall_err <= 1'b1;
            state <= W_STAT;
          end else begin
            state <= IDLE;
          end
        end
        // A stopped timer is re-armed by replaying the control write.
        W_STAT: state <= restart ? W_CTRL : GUARD;
        GUARD:  state <= IDLE;
        default: state <= W_PERL;
      endcase
    end
  end

  logic [4:0] set_hh_c;
  logic [5:0] set_mm_c;
  logic [5:0] set_ss_c;

  always_comb begin
    set_hh_c = (set_hh > 5'd23) ? 5'd23 : set_hh;
    set_mm_c = (set_mm > 6'd59) ? 6'd59 : set_mm;
    set_ss_c = (set_ss > 6'd59) ? 6'd59 : set_ss;
  end

  // A load on the same edge as a tick wins; that second is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hh <= 5'd0;
      mm <= 6'd0;
      ss <= 6'd0;
    end else if (set_valid) begin
      hh <= set_hh_c;
      mm <= set_mm_c;
      ss <= set_ss_c;
    end else if (tick) begin
      if (ss == 6'd59) begin
        ss <= 6'd0;
        if (mm == 6'd59) begin
          mm <= 6'd0;
          hh <= (hh == 5'd23) ? 5'd0 : hh + 5'd1;
        end else begin
          mm <= mm + 6'd1;
        end
      end else begin
        ss <= ss + 6'd1;
      end
    end
  end

endmodule

// File: doc/timer_tick_master.md
Name: timer_tick_master

Overview:
- Avalon-MM master that drives the system interval-timer slave (16-bit data, 3-bit word address, registered readdata, no waitrequest) from hardware, without the Nios II.
- Programs the period, then starts the timer in continuous mode with interrupts enabled.
- Services each timer IRQ: verifies status, then clears it.
- Converts each timeout into a 1-second tick and keeps a 24-hour HH:MM:SS time-of-day for the alarm-clock datapath.

Parameters:
- PERIOD, 32'd49_999_999, value written to period_h:period_l; timer interval is PERIOD+1 clk cycles.
- CTRL_START, 16'h0007, control word written at start: bit0 ITO, bit1 CONT, bit2 START.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- av_address  out  3  timer word address (0 status, 1 control, 2 period_l, 3 period_h)
- av_chipselect  out  1  bus cycle valid
- av_write_n  out  1  active-low write
- av_writedata  out  16  write data
- av_readdata  in  16  timer readdata, valid the cycle after the address is presented
- timer_irq  in  1  timer interrupt request
- set_valid  in  1  one-cycle strobe: load set_hh/set_mm/set_ss
- set_hh  in  5  hours to load, 0-23
- set_mm  in  6  minutes to load, 0-59
- set_ss  in  6  seconds to load, 0-59
- init_done  out  1  high once the timer has been started
- tick  out  1  one-cycle pulse per serviced timeout
- hh  out  5  hours
- mm  out  6  minutes
- ss  out  6  seconds
- stall_err  out  1  sticky: timer found not running

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0, except av_write_n=1.
  - FSM in W_PERL.
- Bus idle state: av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0.
- Writes: every write is exactly one cycle, with chipselect=1, write_n=0, and address/data valid. No waitrequest; the next state follows unconditionally.
- FSM states and transitions:
  - W_PERL: write addr 2, PERIOD[15:0] -> W_PERH.
  - W_PERH: write addr 3, PERIOD[31:16] -> W_CTRL.
  - W_CTRL: write addr 1, CTRL_START -> IDLE. init_done is set at this edge and stays 1 until reset.
  - IDLE: bus idle. timer_irq=1 -> RD_ADDR.
  - RD_ADDR: chipselect=1, write_n=1, addr 0 -> RD_CAP.
  - RD_CAP: bus idle; sample av_readdata.
    - bit0 (TO)=0: spurious IRQ -> IDLE, no tick.
    - bit0=1 -> W_STAT.
    - bit1 (RUN)=0: set stall_err; after W_STAT go to W_CTRL instead of GUARD (restarts the timer).
  - W_STAT: write addr 0, data 0 (clears TO). tick=1 in this cycle -> GUARD, or W_CTRL if RUN was 0.
  - GUARD: bus idle for one cycle so the slave's registered irq can fall -> IDLE.
- IRQ service latency: 4 cycles from entering RD_ADDR to re-entering IDLE. Minimum PERIOD for lossless ticks is 5.
- Timekeeping (updated on tick):
  - ss increments; at 59 it wraps to 0 and carries to mm.
  - mm at 59 wraps to 0 and carries to hh.
  - hh at 23 wraps to 0.
  - Full wrap: 23:59:59 -> 00:00:00.
- set_valid:
  - Loads hh/mm/ss next edge in any state.
  - Priority over a simultaneous tick: the load wins and that increment is dropped. The tick pulse is still emitted.
  - Out-of-range set values (hh>23, mm/ss>59) are clamped to the max legal value.
- timer_irq while not in IDLE is ignored; the level is re-examined on return to IDLE.
- stall_err clears only on reset.
- Reset mid-transaction: bus returns to idle immediately (async). Init restarts at W_PERL when reset_n rises.

Test Plan:
- Init: PERIOD=32'h0001_86A0, release reset -> writes (2,16'h86A0), (3,16'h0001), (1,16'h0007) on three consecutive cycles; init_done=1 after the third.
- Normal IRQ: slave model raises irq, returns readdata=16'h0003 -> read at addr 0, write (0,16'h0000), one tick pulse, ss 00->01, back to IDLE 4 cycles after RD_ADDR.
- Spurious IRQ: readdata=16'h0002 -> no status write, no tick, ss unchanged.
- Stall: readdata=16'h0001 -> status write, then control write 16'h0007; stall_err=1 and stays 1.
- Wrap and set: set 23:59:59, one tick -> 00:00:00; set_valid with 12:30:45 coincident with tick -> 12:30:45, tick pulse seen; set_mm=63 -> mm=59.
- Reset mid-op: assert reset_n=0 during W_STAT -> chipselect=0 and write_n=1 asynchronously; after release, the init sequence repeats and hh:mm:ss=00:00:00.
